n64_reset_monitor: RTL and testbench
====================================

Name: n64_reset_monitor

Overview:
- Conditions the console reset line (N64 nRST) and the PLL lock flag into one clean, registered, low-active reset request, nrst_o.
- nrst_o drives the async_nrst_i input of the downstream two-stage reset generator.
- Classifies console reset-button activity into pressed, short-press and long-press events for the controller and menu logic.
- All sequential logic runs in the clk domain.

Parameters:
- sync_stages, 2: number of synchronizer flops on n64_nrst_i and pll_locked_i; minimum 2.
- debounce_len, 4096: consecutive clk_en samples the synchronized n64_nrst_i must hold a new level before it is accepted; minimum 2.
- long_press_len, 16777216: clk_en cycles the debounced press must last before long_press_o fires; must be greater than debounce_len.
- rst_on_press, 1'b1: 1 = nrst_o is also held low while the button is debounced-pressed.

Ports:
- clk, in, 1: system clock.
- async_rst_i, in, 1: asynchronous reset, active-high.
- clk_en, in, 1: advances the debounce and hold counters and the FSM. Synchronizers run every clk.
- n64_nrst_i, in, 1: console reset, low-active, asynchronous to clk.
- pll_locked_i, in, 1: PLL lock, asynchronous to clk.
- rst_req_i, in, 1: synchronous software reset request, active-high.
- nrst_o, out, 1: combined reset request, low-active, registered.
- pressed_o, out, 1: high while a debounced press is in progress (PRESSED or HELD).
- short_press_o, out, 1: one-clk pulse on release before long_press_len is reached.
- long_press_o, out, 1: one-clk pulse when the hold reaches long_press_len.

Behaviour:
- Reset (async_rst_i=1, applied immediately):
  - n64_nrst_i synchronizer flops = 1; pll_locked_i synchronizer flops = 0.
  - stable level = 1; debounce and hold counters = 0; FSM = IDLE.
  - nrst_o = 0; pressed_o = 0; short_press_o = 0; long_press_o = 0.
- Synchronizers: plain flop chains clocked every clk, not gated by clk_en.
- Debounce, on clk_en cycles only:
  - If the synchronized sample differs from the stable level, the counter increments.
  - If the sample equals the stable level, the counter clears to 0.
  - When the counter reaches debounce_len-1 while the sample still differs, the stable level toggles and the counter clears in the same cycle.
  - Counter width is $clog2(debounce_len). It never wraps, because it clears at the threshold.
- FSM, on clk_en cycles; states IDLE, PRESSED, HELD:
  - IDLE: stable level falls -> PRESSED, hold counter = 0.
  - PRESSED: hold counter increments each clk_en cycle.
  - PRESSED: hold counter reaches long_press_len-1 -> HELD, long_press_o pulses.
  - PRESSED: stable level rises -> IDLE, short_press_o pulses.
  - A stable-level rise takes priority over the long-press threshold in the same cycle, giving a short press.
  - HELD: stable level rises -> IDLE, no pulse.
  - Hold counter width is $clog2(long_press_len). It is frozen in HELD.
- Pulses are exactly one clk wide, even when clk_en is held high. They are never asserted without a state transition.
- pressed_o is registered and equals (state != IDLE) one clk after the transition.
- nrst_o is registered with one clk latency:
  - nrst_o = 0 if the synchronized pll_locked is 0, or rst_req_i = 1, or (rst_on_press = 1 and state != IDLE); otherwise nrst_o = 1.
  - nrst_o is evaluated every clk, independent of clk_en.
- Input glitches shorter than debounce_len clk_en samples have no effect on any output.
- Latency with clk_en = 1 from a clean n64_nrst_i falling edge to pressed_o high: sync_stages + debounce_len + 1 clk.
- async_rst_i asserted mid-press returns the block to its reset state. No pulse is emitted, and the hold is forgotten.
- After release of async_rst_i, nrst_o stays 0 until pll_locked has passed through the synchronizer and the other terms allow release.

Decomposition:
- Shared package n64adv_reset_pkg holds:
  - the FSM state encodings: ST_IDLE = 2'd0, ST_PRESSED = 2'd1, ST_HELD = 2'd2;
  - the default debounce and long-press constants.
- One sub-module, debounce_sync, instantiated once for n64_nrst_i. It contains the synchronizer chain plus the debounce counter, and outputs the stable level.
- The pll_locked_i synchronizer is an inline flop chain.

Test Plan (debounce_len = 8, long_press_len = 64, clk_en = 1 unless stated):
- Reset, PLL and software request:
  - Assert async_rst_i, pll_locked_i = 1, n64_nrst_i = 1 -> all outputs 0 during reset.
  - Release async_rst_i -> nrst_o = 1 exactly sync_stages + 1 clk later.
  - Drop pll_locked_i for 1 clk -> nrst_o goes 0.
  - rst_req_i = 1 for 1 clk -> nrst_o = 0 for exactly 1 clk.
- Glitch rejection: pulse n64_nrst_i low for 7 clk, repeated 3 times -> pressed_o, short_press_o, long_press_o and nrst_o unchanged.
- Short press:
  - Hold n64_nrst_i low for 30 clk, then release -> pressed_o rises at edge + 11 clk.
  - nrst_o = 0 while pressed.
  - Exactly one short_press_o pulse; no long_press_o.
- Long press:
  - Hold n64_nrst_i low for 200 clk -> one long_press_o pulse at 64 clk after pressed_o rises.
  - Release -> no short_press_o; pressed_o falls.
- clk_en duty: clk_en = 1 every 4th clk, low input held for 31 clk -> no press accepted. Held for 40 clk -> press accepted; all pulses still 1 clk wide.
- Reset mid-press: assert async_rst_i while in HELD, release it, then release n64_nrst_i -> no pulses; FSM returns to IDLE; pressed_o = 0.

Source files
------------

// File: rtl/n64adv_reset_pkg.sv
// Shared definitions for the N64 console reset monitor: FSM encodings and
// default timing constants.
package n64adv_reset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned DEBOUNCE_LEN_DEF   = 4096;
    localparam int unsigned LONG_PRESS_LEN_DEF = 16777216;

endpackage

// File: rtl/n64_reset_monitor_debounce_sync.sv
// Synchronizer chain plus debounce counter for one asynchronous input.
// stable_o only changes after the synchronized sample has disagreed with it
// for debounce_len consecutive clk_en samples.
module debounce_sync
    import n64adv_reset_pkg::*;
#(
    parameter int unsigned sync_stages  = SYNC_STAGES_DEF,
    parameter int unsigned debounce_len = DEBOUNCE_LEN_DEF,
    parameter logic        rst_level    = 1'b1
) (
    input  logic clk,
    input  logic async_rst_i,
    input  logic clk_en,
    input  logic async_i,
    output logic stable_o
);

    localparam int unsigned    CNT_W   = $clog2(debounce_len);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(debounce_len - 1);

    logic [sync_stages-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   w_sample;

    assign w_sample = r_sync[sync_stages-1];
    assign stable_o = r_stable;

    // Synchronizer runs every clk so metastability settling is not stretched by clk_en.
    always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_sync <= {sync_stages{rst_level}};
        end else begin
            r_sync <= {r_sync[sync_stages-2:0], async_i};
        end
    end

    // Count disagreeing samples; accept the new level on the last one and restart.
    always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_stable <= rst_level;
            r_cnt    <= '0;
        end else if (clk_en) begin
            if (w_sample == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/n64_reset_monitor.sv
// Console reset / PLL lock conditioning and reset-button press classifier.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | button released (debounced level high)
//   ST_PRESSED | button held, counting toward the long-press threshold
//   ST_HELD    | long press already reported, waiting for release
module n64_reset_monitor
    import n64adv_reset_pkg::*;
#(
    parameter int unsigned sync_stages    = SYNC_STAGES_DEF,
    parameter int unsigned debounce_len   = DEBOUNCE_LEN_DEF,
    parameter int unsigned long_press_len = LONG_PRESS_LEN_DEF,
    parameter bit          rst_on_press   = 1'b1
) (
    input  logic clk,
    input  logic async_rst_i,
    input  logic clk_en,
    input  logic n64_nrst_i,
    input  logic pll_locked_i,
    input  logic rst_req_i,
    output logic nrst_o,
    output logic pressed_o,
    output logic short_press_o,
    output logic long_press_o
);

    localparam int unsigned       HOLD_W   = $clog2(long_press_len);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(long_press_len - 1);

    logic                   w_stable;
    logic [sync_stages-1:0] r_pll_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [HOLD_W-1:0]      r_hold;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic                   w_short;
    logic                   w_long;
    logic                   r_nrst;
    logic                   r_pressed;
    logic                   r_short;
    logic                   r_long;

    debounce_sync #(
        .sync_stages  (sync_stages),
        .debounce_len (debounce_len),
        .rst_level    (1'b1)
    ) u_nrst_deb (
        .clk         (clk),
        .async_rst_i (async_rst_i),
        .clk_en      (clk_en),
        .async_i     (n64_nrst_i),
        .stable_o    (w_stable)
    );

    // PLL lock synchronizer; resets to "unlocked" so nrst_o holds after reset.
    always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_pll_sync <= '0;
        end else begin
            r_pll_sync <= {r_pll_sync[sync_stages-2:0], pll_locked_i};
        end
    end

    // Next state, hold count and event pulses; a release wins over the long-press threshold.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_short     = 1'b0;
        w_long      = 1'b0;
        if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_stable) begin
                        w_state_nxt = ST_PRESSED;
                        w_hold_nxt  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (w_stable) begin
                        w_state_nxt = ST_IDLE;
                        w_short     = 1'b1;
                    end else if (r_hold == HOLD_MAX) begin
                        w_state_nxt = ST_HELD;
                        w_long      = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_stable) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, hold counter and registered press outputs.
    always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_pressed <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_pressed <= (w_state_nxt != ST_IDLE);
            r_short   <= w_short;
            r_long    <= w_long;
        end
    end

    // Combined low-active reset request, evaluated every clk regardless of clk_en.
    always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_nrst <= 1'b0;
        end else begin
            r_nrst <= r_pll_sync[sync_stages-1] & ~rst_req_i
                      & ~(rst_on_press & (r_state != ST_IDLE));
        end
    end

    assign nrst_o        = r_nrst;
    assign pressed_o     = r_pressed;
    assign short_press_o = r_short;
    assign long_press_o  = r_long;

endmodule

// File: tb/tb_n64_reset_monitor.sv
// Bench for n64_reset_monitor: expected press events are queued with their
// cycle when stimulus is applied and matched as the DUT emits them.
module tb_n64_reset_monitor;

    localparam int SYNC      = 2;
    localparam int DEB       = 8;
    localparam int LONG      = 64;
    localparam int PRESS_LAT = SYNC + DEB + 1;

    logic clk = 1'b0;
    logic async_rst_i;
    logic clk_en;
    logic n64_nrst_i;
    logic pll_locked_i;
    logic rst_req_i;
    logic nrst_o;
    logic pressed_o;
    logic short_press_o;
    logic long_press_o;

    int   cyc          = 0;
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   nrst_low_cnt = 0;
    int   lo_before;
    int   t0;
    logic prev_pressed = 1'b0;

    typedef struct {
        byte kind;
        int  cyc;
    } ev_t;

    ev_t sb_q[$];

    n64_reset_monitor #(
        .sync_stages    (SYNC),
        .debounce_len   (DEB),
        .long_press_len (LONG),
        .rst_on_press   (1'b1)
    ) dut (
        .clk           (clk),
        .async_rst_i   (async_rst_i),
        .clk_en        (clk_en),
        .n64_nrst_i    (n64_nrst_i),
        .pll_locked_i  (pll_locked_i),
        .rst_req_i     (rst_req_i),
        .nrst_o        (nrst_o),
        .pressed_o     (pressed_o),
        .short_press_o (short_press_o),
        .long_press_o  (long_press_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input byte k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic sb_match(input byte k);
        ev_t e;
        chk($sformatf("sb_has_%c", k), 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("ev_kind_%c", k), 32'(k), 32'(e.kind));
            chk($sformatf("ev_cyc_%c", k), cyc, e.cyc);
        end
    endtask

    // Monitor: every pressed_o edge and every pulse cycle is one event.
    always @(negedge clk) begin
        if (nrst_o !== 1'b1) nrst_low_cnt++;
        if (pressed_o !== prev_pressed) begin
            sb_match(pressed_o ? "P" : "R");
            prev_pressed = pressed_o;
        end
        if (long_press_o !== 1'b0) sb_match("L");
        if (short_press_o !== 1'b0) sb_match("S");
    end

    // Press of 'hold' clk with clk_en=1. A release that reaches the FSM no later
    // than the long-press threshold cycle counts as a short press.
    task automatic press(input int hold);
        int  ts;
        bit  is_long;
        ts      = cyc;
        is_long = (hold > LONG);
        n64_nrst_i = 1'b0;
        expect_ev("P", ts + PRESS_LAT);
        if (is_long) expect_ev("L", ts + PRESS_LAT + LONG);
        expect_ev("R", ts + hold + PRESS_LAT);
        if (!is_long) expect_ev("S", ts + hold + PRESS_LAT);
        step(hold);
        chk("press_nrst_low", nrst_o, 0);
        n64_nrst_i = 1'b1;
        step(PRESS_LAT + 2);
        chk("release_nrst_high", nrst_o, 1);
        chk("release_pressed", pressed_o, 0);
        step(5);
    endtask

    // clk_en high only before edges t+2, t+6, ...; input low for edges t+1..t+low_len.
    task automatic duty_run(input int low_len, input int total);
        for (int j = 0; j < total; j++) begin
            clk_en     = ((j + 1) % 4 == 2);
            n64_nrst_i = (j < low_len) ? 1'b0 : 1'b1;
            step(1);
        end
        clk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst_i  = 1'b1;
        pll_locked_i = 1'b1;
        n64_nrst_i   = 1'b1;
        rst_req_i    = 1'b0;
        clk_en       = 1'b1;
        step(3);
        chk("rst_nrst", nrst_o, 0);
        chk("rst_pressed", pressed_o, 0);
        chk("rst_short", short_press_o, 0);
        chk("rst_long", long_press_o, 0);

        async_rst_i = 1'b0;
        step(SYNC);
        chk("nrst_before_release", nrst_o, 0);
        step(1);
        chk("nrst_release", nrst_o, 1);
        step(2);

        pll_locked_i = 1'b0;
        step(1);
        pll_locked_i = 1'b1;
        step(1);
        chk("pll_drop_e2", nrst_o, 1);
        step(1);
        chk("pll_drop_e3", nrst_o, 0);
        step(1);
        chk("pll_drop_e4", nrst_o, 1);
        step(2);

        rst_req_i = 1'b1;
        step(1);
        rst_req_i = 1'b0;
        chk("swreq_low", nrst_o, 0);
        step(1);
        chk("swreq_high", nrst_o, 1);
        step(3);

        lo_before = nrst_low_cnt;
        repeat (3) begin
            n64_nrst_i = 1'b0;
            step(DEB - 1);
            n64_nrst_i = 1'b1;
            step(12);
        end
        chk("glitch_nrst_low_cycles", nrst_low_cnt - lo_before, 0);
        chk("glitch_pressed", pressed_o, 0);

        press(30);
        press(200);
        press(LONG);
        press(LONG + 1);

        // 31 clk low spans only 7 clk_en samples with this phase: rejected.
        duty_run(31, 60);
        chk("duty31_pressed", pressed_o, 0);
        step(5);
        // 40 clk low: 8th low sample at edge t+34, FSM enters PRESSED at the
        // next clk_en edge t+38; release seen from edge t+43, 8th high sample
        // at t+74, FSM back to IDLE at t+78.
        t0 = cyc;
        expect_ev("P", t0 + 38);
        expect_ev("R", t0 + 78);
        expect_ev("S", t0 + 78);
        duty_run(40, 100);
        chk("duty40_pressed", pressed_o, 0);
        step(5);

        t0 = cyc;
        n64_nrst_i = 1'b0;
        expect_ev("P", t0 + PRESS_LAT);
        expect_ev("L", t0 + PRESS_LAT + LONG);
        step(100);
        chk("held_pressed", pressed_o, 1);
        expect_ev("R", t0 + 100);
        async_rst_i = 1'b1;
        #1;
        chk("midrst_pressed", pressed_o, 0);
        chk("midrst_nrst", nrst_o, 0);
        step(3);
        async_rst_i = 1'b0;
        step(2);
        n64_nrst_i = 1'b1;
        chk("midrst_nrst_hold", nrst_o, 0);
        step(1);
        chk("midrst_nrst_release", nrst_o, 1);
        step(30);
        chk("midrst_idle_pressed", pressed_o, 0);

        press(20);

        step(5);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
